// File: rtl/alu_scan_pkg.sv
// ---------------------------------------------------------------------------
// alu_scan_pkg
// Shared definitions for the ALU + multiplexed 7-segment scanner.
//   - op_e      : ALU opcode encoding (OP_ADD .. OP_DEC); codes 10-15 are illegal
//   - SEG_BLANK : active-low segment pattern with every segment dark
//   - hex_to_seg: 4-bit nibble -> active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package alu_scan_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  // X + Y + c_in
    OP_SUB = 4'd1,  // X - Y - c_in
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,  // ~X
    OP_SHL = 4'd6,  // X << 1
    OP_SHR = 4'd7,  // X >> 1, logical
    OP_INC = 4'd8,  // X + 1
    OP_DEC = 4'd9   // X - 1
  } op_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segments are active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;  // F
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// ---------------------------------------------------------------------------
// hex_seg_decode
// Combinational hex digit decoder.
//   nibble : in  [3:0]  hex value 0-F
//   seg_n  : out [6:0]  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_seg_decode
  import alu_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex_to_seg(nibble);

endmodule

// File: rtl/alu_hex_scan.sv
// ---------------------------------------------------------------------------
// alu_hex_scan
// Single-cycle registered ALU whose result is shown in hex on a
// time-multiplexed, active-low 7-segment display.
//
// Parameters
//   DATA_W      operand/result width, multiple of 4 in 4..32
//   NUM_DIGITS  number of display digits, 4*NUM_DIGITS >= DATA_W
//   REFRESH_DIV clocks each digit stays lit, >= 2
//
// Ports
//   clock_100Mhz   in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   X, Y           in   [DATA_W-1:0] operands
//   c_in           in   carry/borrow in
//   Op             in   [3:0] opcode (see alu_scan_pkg::op_e)
//   start          in   load strobe; operands sampled on the same edge
//   result         out  [DATA_W-1:0] registered result
//   c_out          out  carry (add/inc), borrow (sub/dec), shifted-out bit
//   zero           out  result == 0
//   err            out  last accepted opcode was illegal
//   done           out  one-cycle pulse when result/flags update
//   Anode_Activate out  [NUM_DIGITS-1:0] active-low digit enables
//   LED_out        out  [6:0] active-low segments {g,f,e,d,c,b,a}
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//   non-zero nibble are blanked (digit 0 always shown); anodes still scan.
// ---------------------------------------------------------------------------
module alu_hex_scan
  import alu_scan_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     X,
  input  logic [DATA_W-1:0]     Y,
  input  logic                  c_in,
  input  logic [3:0]            Op,
  input  logic                  start,
  output logic [DATA_W-1:0]     result,
  output logic                  c_out,
  output logic                  zero,
  output logic                  err,
  output logic                  done,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DISP_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // -------------------------------------------------------------------------
  // ALU datapath (combinational, captured on start)
  // -------------------------------------------------------------------------
  logic [DATA_W:0]   x_ext;
  logic [DATA_W:0]   y_ext;
  logic [DATA_W:0]   cin_ext;
  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              alu_err;

  assign x_ext   = {1'b0, X};
  assign y_ext   = {1'b0, Y};
  assign cin_ext = {{DATA_W{1'b0}}, c_in};

  always_comb begin
    alu_wide = '0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    case (Op)
      OP_ADD: begin
        alu_wide = x_ext + y_ext + cin_ext;
        alu_cout = alu_wide[DATA_W];
      end
      OP_SUB: begin
        // The extra top bit goes high exactly when the difference wraps below 0.
        alu_wide = x_ext - y_ext - cin_ext;
        alu_cout = alu_wide[DATA_W];
      end
      OP_AND: alu_wide = {1'b0, X & Y};
      OP_OR:  alu_wide = {1'b0, X | Y};
      OP_XOR: alu_wide = {1'b0, X ^ Y};
      OP_NOT: alu_wide = {1'b0, ~X};
      OP_SHL: begin
        alu_wide = {1'b0, X[DATA_W-2:0], 1'b0};
        alu_cout = X[DATA_W-1];
      end
      OP_SHR: begin
        alu_wide = {2'b00, X[DATA_W-1:1]};
        alu_cout = X[0];
      end
      OP_INC: begin
        alu_wide = x_ext + (DATA_W+1)'(1);
        alu_cout = alu_wide[DATA_W];
      end
      OP_DEC: begin
        alu_wide = x_ext - (DATA_W+1)'(1);
        alu_cout = alu_wide[DATA_W];
      end
      default: alu_err = 1'b1;  // result and carry stay 0
    endcase
  end

  assign alu_result = alu_wide[DATA_W-1:0];

  // -------------------------------------------------------------------------
  // State: ALU output registers and scan position
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] result_q,      result_d;
  logic              c_out_q,       c_out_d;
  logic              zero_q,        zero_d;
  logic              err_q,         err_d;
  logic              done_q,        done_d;
  logic [CNT_W-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0]  digit_idx_q,   digit_idx_d;

  always_comb begin
    result_d      = result_q;
    c_out_d       = c_out_q;
    zero_d        = zero_q;
    err_d         = err_q;
    done_d        = 1'b0;
    refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    digit_idx_d   = digit_idx_q;

    if (start) begin
      result_d = alu_result;
      c_out_d  = alu_cout;
      zero_d   = (alu_result == '0);
      err_d    = alu_err;
      done_d   = 1'b1;
    end

    // The scan free-runs; start never disturbs it.
    if (refresh_cnt_q == CNT_MAX) begin
      refresh_cnt_d = '0;
      digit_idx_d   = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      result_q      <= '0;
      c_out_q       <= 1'b0;
      zero_q        <= 1'b1;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
    end else begin
      result_q      <= result_d;
      c_out_q       <= c_out_d;
      zero_q        <= zero_d;
      err_q         <= err_d;
      done_q        <= done_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
    end
  end

  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
  assign err    = err_q;
  assign done   = done_q;

  // -------------------------------------------------------------------------
  // Display: driven straight from result_q so a new value shows immediately
  // -------------------------------------------------------------------------
  logic [DISP_W-1:0]     disp_word;
  logic [3:0]            digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_blank;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;

  assign disp_word = DISP_W'(result_q);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi]      = disp_word[4*gi +: 4];
    assign Anode_Activate[gi] = (digit_idx_q != IDX_W'(gi));
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every nibble above it are zero.
    if (gi == 0) begin : g_keep
      assign digit_blank[gi] = 1'b0;
    end else begin : g_lz
      assign digit_blank[gi] = ~|disp_word[DISP_W-1:4*gi];
    end
`else
    assign digit_blank[gi] = 1'b0;
`endif
  end

  assign cur_nib = digit_nib[digit_idx_q];

  hex_seg_decode u_dec (
    .nibble (cur_nib),
    .seg_n  (cur_seg)
  );

  assign LED_out = digit_blank[digit_idx_q] ? SEG_BLANK : cur_seg;

endmodule

// File: doc/alu_hex_scan.md
ALU_HEX_SCAN -- requirements
Module: alu_hex_scan

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL be a multiple of 4 in range 4..32.
REQ-002 Parameter NUM_DIGITS, default 8, number of 7-segment digits; SHALL satisfy 4*NUM_DIGITS >= DATA_W.
REQ-003 Parameter REFRESH_DIV, default 100000, clocks per digit slot; SHALL be >= 2.
REQ-004 One clock and one reset: reset is synchronous and active-high.
REQ-005 clock_100Mhz  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 X, Y  in  DATA_W  operands; c_in  in  1  carry/borrow in; Op  in  4  opcode.
REQ-008 start  in  1  one-cycle load strobe; samples X, Y, Op, c_in.
REQ-009 result  out  DATA_W  registered ALU result; c_out  out  1  carry out; zero  out  1  result==0; err  out  1  illegal opcode.
REQ-010 done  out  1  one-cycle pulse when result/flags update.
REQ-011 Anode_Activate  out  NUM_DIGITS  active-low digit enables; LED_out  out  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-012 Op encoding: 0 X+Y+c_in; 1 X-Y-c_in; 2 AND; 3 OR; 4 XOR; 5 NOT X; 6 X<<1; 7 X>>1 (logical); 8 X+1; 9 X-1; 10-15 illegal.
REQ-013 Arithmetic computed at DATA_W+1 bits; c_out = bit DATA_W for ops 0,8 (carry) and ops 1,9 (borrow, 1 when result wrapped below 0); op 6 c_out = X[DATA_W-1], op 7 c_out = X[0]; logic ops c_out = 0.
REQ-014 Illegal Op: result = 0, c_out = 0, zero = 1, err = 1; legal Op clears err.
REQ-015 Latency: start at edge N -> result, c_out, zero, err, done valid after edge N+1; done high exactly one cycle.
REQ-016 start back-to-back every cycle accepted; each produces its own done pulse; no busy state.
REQ-017 Without start, result/flags hold; done = 0.
REQ-018 Display word = result zero-extended to 4*NUM_DIGITS; digit i shows nibble i as hex 0-F.
REQ-019 Refresh counter counts 0..REFRESH_DIV-1; on terminal count wraps to 0 and digit index advances; index NUM_DIGITS-1 wraps to 0.
REQ-020 Exactly one Anode_Activate bit low at any time (the current index); LED_out is the decode of that digit's nibble in the same cycle.
REQ-021 New result visible on scanned digits the cycle it is registered; scan position unaffected by start.

Reset
REQ-022 reset high: result = 0, c_out = 0, zero = 1, err = 0, done = 0, refresh counter = 0, digit index = 0 (Anode_Activate = ~1, LED_out = pattern for "0").
REQ-023 reset asserted concurrently with start: reset wins, operands discarded, no done pulse.
REQ-024 reset mid-scan returns to digit 0 on the next edge.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, digits above the most significant non-zero nibble drive LED_out = 7'h7F (blank) while their anode still scans; digit 0 never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, all NUM_DIGITS digits show hex including leading zeros.

Structure
REQ-027 Shared package alu_scan_pkg SHALL hold opcode constants (OP_ADD..OP_DEC), segment constant SEG_BLANK and the 16-entry hex-to-segment function.
REQ-028 One sub-module hex_seg_decode (4-bit nibble in, 7-bit active-low segments out, combinational); ALU and scanner live in alu_hex_scan.

Verification
REQ-029 DATA_W=8: X=8'hFF, Y=8'h01, c_in=0, Op=0, start -> next cycle result=8'h00, c_out=1, zero=1, done one cycle.
REQ-030 Op=1, X=8'h03, Y=8'h05 -> result=8'hFE, c_out=1; Op=7, X=8'h81 -> result=8'h40, c_out=1.
REQ-031 Op=4'hC -> result=0, err=1; following Op=2, X=8'hF0, Y=8'h3C -> result=8'h30, err=0.
REQ-032 REFRESH_DIV=4, NUM_DIGITS=8: anode walks 8'hFE,8'hFD,...,8'h7F,8'hFE, 4 cycles per digit; result=8'hA5 -> digit0 LED_out=hex "5", digit1 "A", digits2-7 "0" (blank with LEADING_ZERO_BLANK_EN).
REQ-033 reset asserted with start and mid-scan -> outputs per REQ-022 next edge, no done pulse.
